// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// ahblite_busmatrix_arbiter_rr
//   Output-stage arbiter for one slave port of an AHB-Lite bus matrix. Grants one of
//   NUM_MASTERS input stages in round-robin order. The grant is held for the whole of a
//   fixed-length or INCR burst. State only advances on HREADY_Outputstage. Build with
//   ARB_LOCK_EN defined to make the owner's HMASTLOCK freeze the grant.
//
// Ports
//   HCLK, HRESET           clock, synchronous active-high reset
//   REQ                    per-master request for this port (bit i = master i)
//   HREADY_Outputstage     slave-side HREADY; arbiter advances only when high
//   HSEL_Outputstage       current owner's address phase targets this port
//   HTRANS_Outputstage     current owner's HTRANS
//   HBURST_Outputstage     current owner's HBURST
//   HMASTLOCK_Outputstage  current owner's HMASTLOCK (ignored unless ARB_LOCK_EN)
//   PORT_SEL_ARBITER       registered index of the granted master
//   PORT_NOSEL_ARBITER     registered; 1 = no master owns the port
//   BURST_ACTIVE           registered; 1 = grant held for a burst (or lock)
module ahblite_busmatrix_arbiter_rr #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned SEL_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] REQ,
  input  logic                   HREADY_Outputstage,
  input  logic                   HSEL_Outputstage,
  input  logic [1:0]             HTRANS_Outputstage,
  input  logic [2:0]             HBURST_Outputstage,
  input  logic                   HMASTLOCK_Outputstage,
  output logic [SEL_W-1:0]       PORT_SEL_ARBITER,
  output logic                   PORT_NOSEL_ARBITER,
  output logic                   BURST_ACTIVE
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [1:0] {StNoPort, StOwned, StBurst, StLock} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;   // last granted master
  logic [3:0]       cnt_q, cnt_d;   // beats remaining minus 1
  logic             incr_q, incr_d; // current burst is undefined-length

  logic             lock_req;
  logic             rr_found;
  logic [SEL_W-1:0] rr_winner;
  logic             burst_multi;
  logic             burst_incr;
  logic [3:0]       burst_init;
  logic             hold;

`ifdef ARB_LOCK_EN
  assign lock_req = HSEL_Outputstage & HMASTLOCK_Outputstage;
`else
  logic unused_lock;
  assign unused_lock = HMASTLOCK_Outputstage;
  assign lock_req    = 1'b0;
`endif

  // Round-robin scan starting one past the last granted master, wrapping at NUM_MASTERS.
  always_comb begin : rr_scan
    int unsigned idx;
    rr_found  = 1'b0;
    rr_winner = ptr_q;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!rr_found && REQ[idx[SEL_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = idx[SEL_W-1:0];
      end
    end
  end

  // Burst length decode; burst_init is the counter load (length - 2).
  always_comb begin
    burst_multi = 1'b1;
    burst_incr  = 1'b0;
    burst_init  = 4'd0;
    case (HBURST_Outputstage)
      3'b000:         burst_multi = 1'b0;
      3'b001:         burst_incr  = 1'b1;
      3'b010, 3'b011: burst_init  = 4'd2;
      3'b100, 3'b101: burst_init  = 4'd6;
      default:        burst_init  = 4'd14;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StNoPort;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(NUM_MASTERS - 1);
      cnt_q   <= 4'd0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      incr_q  <= incr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    incr_d  = incr_q;
    hold    = 1'b0;
    if (HREADY_Outputstage) begin
      if (lock_req) begin
        state_d = StLock;
      end else begin
        if (state_q == StBurst && !incr_q) begin
          // Last SEQ beat (cnt_q == 0) falls through to arbitration on this edge.
          if (HSEL_Outputstage && HTRANS_Outputstage == TransSeq) begin
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
              hold  = 1'b1;
            end
          end else if (HTRANS_Outputstage == TransSeq || HTRANS_Outputstage == TransBusy) begin
            hold = 1'b1;
          end
        end else if (state_q == StBurst && incr_q) begin
          if (REQ[sel_q] &&
              (HTRANS_Outputstage == TransSeq || HTRANS_Outputstage == TransBusy)) begin
            hold = 1'b1;
          end
        end

        if (!hold) begin
          if (HSEL_Outputstage && HTRANS_Outputstage == TransNonseq && burst_multi) begin
            state_d = StBurst;
            cnt_d   = burst_init;
            incr_d  = burst_incr;
          end else if (rr_found) begin
            state_d = StOwned;
            sel_d   = rr_winner;
            ptr_d   = rr_winner;
          end else if (!HSEL_Outputstage) begin
            state_d = StNoPort;
          end else begin
            // Owner's final data phase still pending: keep the grant one more cycle.
            state_d = StOwned;
          end
        end
      end
    end
  end

  always_comb begin
    PORT_SEL_ARBITER   = sel_q;
    PORT_NOSEL_ARBITER = (state_q == StNoPort);
    BURST_ACTIVE       = (state_q == StBurst) || (state_q == StLock);
  end

endmodule

// File: doc/ahblite_busmatrix_arbiter_rr.md
Name: ahblite_busmatrix_arbiter_rr

Overview:
- Parametrised output-stage arbiter for the AHB-Lite bus matrix; one instance per slave port (GPIO, SRAM, APB bridge...).
- Selects one of NUM_MASTERS input stages with round-robin priority.
- Holds the grant across fixed-length and undefined-length bursts.
- Updates only on HREADY_Outputstage, and drives the output-stage mux select plus a "no port" flag.

Parameters:
- NUM_MASTERS, 3, number of requesting input stages (2..8).
- SEL_W, $clog2(NUM_MASTERS), width of PORT_SEL_ARBITER. Derived; do not override.

Ports:
- HCLK  input  1  system clock.
- HRESET  input  1  synchronous, active-high reset.
- REQ  input  NUM_MASTERS  per-input-stage request for this slave port; bit i = master i.
- HREADY_Outputstage  input  1  slave-side HREADY; arbiter state advances only when high.
- HSEL_Outputstage  input  1  current owner's address phase targets this port.
- HTRANS_Outputstage  input  2  current owner's HTRANS (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HBURST_Outputstage  input  3  current owner's HBURST.
- HMASTLOCK_Outputstage  input  1  current owner's HMASTLOCK. Used only with ARB_LOCK_EN.
- PORT_SEL_ARBITER  output  SEL_W  registered index of granted master.
- PORT_NOSEL_ARBITER  output  1  registered; 1 = no master owns the port (output stage drives IDLE).
- BURST_ACTIVE  output  1  registered; 1 = grant is held for an in-progress burst.

Behaviour:
- Reset (HRESET=1 at posedge): PORT_SEL_ARBITER=0, PORT_NOSEL_ARBITER=1, BURST_ACTIVE=0, beat counter=0, last-granted pointer=NUM_MASTERS-1 (so master 0 wins first). Reset overrides everything, including mid-burst.
- All registers hold while HREADY_Outputstage=0.
- States: NOPORT (NOSEL=1), OWNED (NOSEL=0, unlocked), BURST (NOSEL=0, BURST_ACTIVE=1).
- Beat length from HBURST: SINGLE=1; INCR=undefined; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16.
- Counter is 4 bits and holds beats remaining minus 1.
- On HREADY=1, evaluated in this priority order:
  1. BURST, fixed length: each HSEL & SEQ decrements the counter. BUSY holds the counter. When the counter=0 and SEQ is accepted, return to arbitration on that same edge. The owner is otherwise kept.
  2. BURST, INCR: hold while the owner's REQ bit=1 and HTRANS is SEQ or BUSY. IDLE, or NONSEQ from the owner, ends the hold on that edge and arbitration applies.
  3. Entry to BURST: HSEL & NONSEQ & length>1 loads counter=length-2 (INCR: counter unused). BURST_ACTIVE=1 on the next cycle. Owner is unchanged.
  4. Arbitration: scan REQ cyclically from pointer+1. The first set bit becomes PORT_SEL_ARBITER and the pointer. NOSEL=0.
     - If the only requester is the current owner, it keeps the port.
  5. No REQ bit set and HSEL_Outputstage=0: NOSEL=1, PORT_SEL_ARBITER holds its last value, pointer unchanged.
  6. No REQ set but HSEL=1 (owner's final data phase pending): keep the current grant, NOSEL=0.
- Latency: REQ sampled at an HREADY edge produces the registered grant the following cycle. No combinational path from REQ to outputs.
- Pointer wrap: after master NUM_MASTERS-1, the scan continues at 0.
- Fairness: with all REQ held high and SINGLE transfers, the grant rotates 0,1,...,N-1,0.
- REQ of the owner dropping mid fixed-length burst: ignored, burst completes. An early-terminated burst is treated as NONSEQ/IDLE and ends the hold.

Optional Feature:
- ARB_LOCK_EN defined: while the owner has HSEL & HMASTLOCK_Outputstage=1 at an HREADY edge, the grant is frozen regardless of REQ and burst state. The lock releases at the first HREADY edge with HMASTLOCK=0, then normal rules apply. BURST_ACTIVE=1 during the lock.
- ARB_LOCK_EN undefined: the HMASTLOCK_Outputstage input is ignored (port kept for interface compatibility).

Test Plan:
- Reset then idle: HRESET pulse, REQ=000 -> SEL=0, NOSEL=1, BURST_ACTIVE=0, stable over 10 cycles.
- Rotation: NUM_MASTERS=3, REQ=111, SINGLE NONSEQ each beat, HREADY=1 -> SEL sequence 0,1,2,0,1 on consecutive cycles after a 1-cycle latency.
- Fixed burst hold: master 1 owns, issues INCR4 NONSEQ+3 SEQ, REQ=111 throughout -> SEL=1 for all 4 beats, then SEL=2 on the edge accepting the 4th beat; wait states (HREADY=0 for 2 cycles mid-burst) freeze all outputs.
- INCR hold: master 0 issues INCR with 6 SEQ plus 1 BUSY, then IDLE, REQ[2]=1 throughout -> SEL=0 until IDLE, then SEL=2.
- Release: owner finishes, REQ=000, HSEL=1 on the final edge -> NOSEL stays 0 one cycle, then NOSEL=1 with SEL unchanged.
- Lock (ARB_LOCK_EN): master 2 asserts HMASTLOCK across 3 SINGLE transfers, REQ=011 -> SEL=2 held; after HMASTLOCK=0, SEL=0. Mid-burst HRESET -> all outputs reset next edge.
